// File: rtl/gnn_node_mlp.sv
// Node-update engine: four nodes, each through a shared 4->4->2 unsigned dense transform,
// computed in parallel in a 3-stage pipeline (capture, hidden layer, output layer).
module gnn_node_mlp #(
  parameter int unsigned FW = 5,
  parameter int unsigned OW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_ready,
  input  logic [FW-1:0] x0_node0, x1_node0, x2_node0, x3_node0,
  input  logic [FW-1:0] x0_node1, x1_node1, x2_node1, x3_node1,
  input  logic [FW-1:0] x0_node2, x1_node2, x2_node2, x3_node2,
  input  logic [FW-1:0] x0_node3, x1_node3, x2_node3, x3_node3,
  input  logic [FW-1:0] w04, w14, w24, w34,
  input  logic [FW-1:0] w05, w15, w25, w35,
  input  logic [FW-1:0] w06, w16, w26, w36,
  input  logic [FW-1:0] w07, w17, w27, w37,
  input  logic [FW-1:0] w48, w58, w68, w78,
  input  logic [FW-1:0] w49, w59, w69, w79,
  output logic [OW-1:0] out0_node0, out1_node0,
  output logic [OW-1:0] out0_node1, out1_node1,
  output logic [OW-1:0] out0_node2, out1_node2,
  output logic [OW-1:0] out0_node3, out1_node3,
  output logic          out10_ready_node0, out11_ready_node0,
  output logic          out10_ready_node1, out11_ready_node1,
  output logic          out10_ready_node2, out11_ready_node2,
  output logic          out10_ready_node3, out11_ready_node3
);

  // Hidden sums: 4 products of two FW-bit values need 2*FW+2 bits.
  localparam int unsigned HW = 2 * FW + 2;

  logic [FW-1:0] x_in  [4][4];  // [node][feature]
  logic [FW-1:0] w1_in [4][4];  // [input k][hidden j-4]
  logic [FW-1:0] w2_in [4][2];  // [hidden j-4][output o-8]

  always_comb begin
    x_in[0][0] = x0_node0; x_in[0][1] = x1_node0; x_in[0][2] = x2_node0; x_in[0][3] = x3_node0;
    x_in[1][0] = x0_node1; x_in[1][1] = x1_node1; x_in[1][2] = x2_node1; x_in[1][3] = x3_node1;
    x_in[2][0] = x0_node2; x_in[2][1] = x1_node2; x_in[2][2] = x2_node2; x_in[2][3] = x3_node2;
    x_in[3][0] = x0_node3; x_in[3][1] = x1_node3; x_in[3][2] = x2_node3; x_in[3][3] = x3_node3;
    w1_in[0][0] = w04; w1_in[1][0] = w14; w1_in[2][0] = w24; w1_in[3][0] = w34;
    w1_in[0][1] = w05; w1_in[1][1] = w15; w1_in[2][1] = w25; w1_in[3][1] = w35;
    w1_in[0][2] = w06; w1_in[1][2] = w16; w1_in[2][2] = w26; w1_in[3][2] = w36;
    w1_in[0][3] = w07; w1_in[1][3] = w17; w1_in[2][3] = w27; w1_in[3][3] = w37;
    w2_in[0][0] = w48; w2_in[1][0] = w58; w2_in[2][0] = w68; w2_in[3][0] = w78;
    w2_in[0][1] = w49; w2_in[1][1] = w59; w2_in[2][1] = w69; w2_in[3][1] = w79;
  end

  logic [FW-1:0] x_q   [4][4];
  logic [FW-1:0] w1_q  [4][4];
  logic [FW-1:0] w2_q  [4][2];
  logic [HW-1:0] h_d   [4][4];
  logic [HW-1:0] h_q   [4][4];
  logic [FW-1:0] w2s_q [4][2];
  logic [OW-1:0] out_d [4][2];
  logic [OW-1:0] out_q [4][2];
  logic          v1_q, v2_q, v3_q;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 4; j++) begin
        h_d[n][j] = '0;
        for (int k = 0; k < 4; k++) begin
          h_d[n][j] = h_d[n][j] + HW'(x_q[n][k]) * HW'(w1_q[k][j]);
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      for (int o = 0; o < 2; o++) begin
        out_d[n][o] = '0;
        for (int j = 0; j < 4; j++) begin
          out_d[n][o] = out_d[n][o] + OW'(h_q[n][j]) * OW'(w2s_q[j][o]);
        end
      end
    end
  end

  // Each stage only loads when its incoming valid is set, so outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        for (int k = 0; k < 4; k++) begin
          x_q[n][k]  <= '0;
          w1_q[n][k] <= '0;
          h_q[n][k]  <= '0;
        end
        for (int o = 0; o < 2; o++) begin
          w2_q[n][o]  <= '0;
          w2s_q[n][o] <= '0;
          out_q[n][o] <= '0;
        end
      end
    end else begin
      v1_q <= in_ready;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (in_ready) begin
        x_q  <= x_in;
        w1_q <= w1_in;
        w2_q <= w2_in;
      end
      if (v1_q) begin
        h_q   <= h_d;
        w2s_q <= w2_q;
      end
      if (v2_q) begin
        out_q <= out_d;
      end
    end
  end

  assign out0_node0 = out_q[0][0];
  assign out1_node0 = out_q[0][1];
  assign out0_node1 = out_q[1][0];
  assign out1_node1 = out_q[1][1];
  assign out0_node2 = out_q[2][0];
  assign out1_node2 = out_q[2][1];
  assign out0_node3 = out_q[3][0];
  assign out1_node3 = out_q[3][1];

  assign out10_ready_node0 = v3_q;
  assign out11_ready_node0 = v3_q;
  assign out10_ready_node1 = v3_q;
  assign out11_ready_node1 = v3_q;
  assign out10_ready_node2 = v3_q;
  assign out11_ready_node2 = v3_q;
  assign out10_ready_node3 = v3_q;
  assign out11_ready_node3 = v3_q;

endmodule

// File: tb/tb_gnn_node_mlp.sv
// Self-checking bench for gnn_node_mlp: directed steps plus random stimulus against a
// dot-product reference model with a two-sample capture delay line.
module tb_gnn_node_mlp;

  logic        clk;
  logic        rst_n;
  logic        in_ready;
  logic [4:0]  x  [4][4];
  logic [4:0]  w1 [4][4];
  logic [4:0]  w2 [4][2];
  logic [19:0] out [4][2];
  logic        rdy [4][2];

  int checks;
  int failures;

  // Reference model state: samples captured on the last two edges, plus held outputs.
  bit pv [2];
  int pr [2][4][2];
  bit ev;
  int eo [4][2];

  gnn_node_mlp #(.FW(5), .OW(20)) dut (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready),
    .x0_node0(x[0][0]), .x1_node0(x[0][1]), .x2_node0(x[0][2]), .x3_node0(x[0][3]),
    .x0_node1(x[1][0]), .x1_node1(x[1][1]), .x2_node1(x[1][2]), .x3_node1(x[1][3]),
    .x0_node2(x[2][0]), .x1_node2(x[2][1]), .x2_node2(x[2][2]), .x3_node2(x[2][3]),
    .x0_node3(x[3][0]), .x1_node3(x[3][1]), .x2_node3(x[3][2]), .x3_node3(x[3][3]),
    .w04(w1[0][0]), .w14(w1[1][0]), .w24(w1[2][0]), .w34(w1[3][0]),
    .w05(w1[0][1]), .w15(w1[1][1]), .w25(w1[2][1]), .w35(w1[3][1]),
    .w06(w1[0][2]), .w16(w1[1][2]), .w26(w1[2][2]), .w36(w1[3][2]),
    .w07(w1[0][3]), .w17(w1[1][3]), .w27(w1[2][3]), .w37(w1[3][3]),
    .w48(w2[0][0]), .w58(w2[1][0]), .w68(w2[2][0]), .w78(w2[3][0]),
    .w49(w2[0][1]), .w59(w2[1][1]), .w69(w2[2][1]), .w79(w2[3][1]),
    .out0_node0(out[0][0]), .out1_node0(out[0][1]),
    .out0_node1(out[1][0]), .out1_node1(out[1][1]),
    .out0_node2(out[2][0]), .out1_node2(out[2][1]),
    .out0_node3(out[3][0]), .out1_node3(out[3][1]),
    .out10_ready_node0(rdy[0][0]), .out11_ready_node0(rdy[0][1]),
    .out10_ready_node1(rdy[1][0]), .out11_ready_node1(rdy[1][1]),
    .out10_ready_node2(rdy[2][0]), .out11_ready_node2(rdy[2][1]),
    .out10_ready_node3(rdy[3][0]), .out11_ready_node3(rdy[3][1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_out(int n, int o);
    int s = 0;
    for (int j = 0; j < 4; j++) begin
      int h = 0;
      for (int k = 0; k < 4; k++) h += int'(x[n][k]) * int'(w1[k][j]);
      s += h * int'(w2[j][o]);
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int n = 0; n < 4; n++) begin
      for (int o = 0; o < 2; o++) begin
        chk($sformatf("out%0d_node%0d", o, n), {12'b0, out[n][o]}, eo[n][o]);
        chk($sformatf("ready%0d_node%0d", o, n), {31'b0, rdy[n][o]}, {31'b0, ev});
      end
    end
  endtask

  // One clock edge: the model samples the pre-edge inputs, then outputs are compared.
  task automatic step();
    int cur [4][2];
    bit cur_rst = !rst_n;
    bit cur_v = in_ready;
    for (int n = 0; n < 4; n++)
      for (int o = 0; o < 2; o++) cur[n][o] = ref_out(n, o);
    @(posedge clk);
    #1;
    if (cur_rst) begin
      pv[0] = 1'b0;
      pv[1] = 1'b0;
      ev = 1'b0;
      for (int n = 0; n < 4; n++)
        for (int o = 0; o < 2; o++) eo[n][o] = 0;
    end else begin
      ev = pv[1];
      if (pv[1]) eo = pr[1];
      pv[1] = pv[0];
      pr[1] = pr[0];
      pv[0] = cur_v;
      pr[0] = cur;
    end
    check_all();
  endtask

  task automatic rand_inputs();
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++) begin
        x[n][k]  = 5'($urandom_range(31));
        w1[n][k] = 5'($urandom_range(31));
      end
    for (int j = 0; j < 4; j++)
      for (int o = 0; o < 2; o++) w2[j][o] = 5'($urandom_range(31));
  endtask

  task automatic set_nominal();
    int xv [16] = '{4, 2, 4, 1, 6, 4, 4, 1, 8, 6, 4, 1, 6, 4, 4, 1};
    int w1v [16] = '{3, 2, 13, 26, 23, 1, 28, 14, 3, 6, 17, 15, 9, 22, 15, 22};
    int w2v [8] = '{0, 31, 3, 21, 20, 17, 17, 6};
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++) x[n][k] = 5'(xv[n*4+k]);
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++) w1[k][j] = 5'(w1v[j*4+k]);
    for (int o = 0; o < 2; o++)
      for (int j = 0; j < 4; j++) w2[j][o] = 5'(w2v[o*4+j]);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    ev = 1'b0;
    for (int n = 0; n < 4; n++)
      for (int o = 0; o < 2; o++) begin
        eo[n][o] = 0;
        pr[0][n][o] = 0;
        pr[1][n][o] = 0;
      end

    // Reset held for 3 cycles with in_ready high.
    rst_n = 1'b0;
    in_ready = 1'b1;
    rand_inputs();
    repeat (3) step();
    chk("reset_out0_node0", {12'b0, out[0][0]}, 0);
    chk("reset_ready", {31'b0, rdy[3][1]}, 0);

    // Nominal vector; flags rise on the third edge after release.
    rst_n = 1'b1;
    set_nominal();
    step();
    step();
    chk("latency_ready_low_e2", {31'b0, rdy[0][0]}, 0);
    step();
    chk("latency_ready_high_e3", {31'b0, rdy[0][0]}, 1);
    chk("nom_out0_node0", {12'b0, out[0][0]}, 10543);
    chk("nom_out1_node0", {12'b0, out[0][1]}, 8411);
    chk("nom_out0_node1", {12'b0, out[1][0]}, 13387);
    chk("nom_out1_node1", {12'b0, out[1][1]}, 10105);
    chk("nom_out0_node2", {12'b0, out[2][0]}, 16231);
    chk("nom_out1_node2", {12'b0, out[2][1]}, 11799);
    chk("nom_out0_node3", {12'b0, out[3][0]}, 13387);
    chk("nom_out1_node3", {12'b0, out[3][1]}, 10105);

    // Back-to-back: node0 zeroed for one sample.
    for (int k = 0; k < 4; k++) x[0][k] = 5'd0;
    step();
    set_nominal();
    step();
    chk("b2b_first", {12'b0, out[0][0]}, 10543);
    step();
    chk("b2b_zero", {12'b0, out[0][0]}, 0);
    step();
    chk("b2b_restored", {12'b0, out[0][0]}, 10543);

    // Maximum operands: no wrap.
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++) begin
        x[n][k] = 5'd31;
        w1[n][k] = 5'd31;
      end
    for (int j = 0; j < 4; j++)
      for (int o = 0; o < 2; o++) w2[j][o] = 5'd31;
    repeat (3) step();
    chk("max_out0_node2", {12'b0, out[2][0]}, 476656);
    chk("max_out1_node3", {12'b0, out[3][1]}, 476656);

    // Bubble: one missing sample drops the flags for one cycle, 3 edges later.
    rand_inputs();
    in_ready = 1'b0;
    step();
    rand_inputs();
    in_ready = 1'b1;
    step();
    step();
    chk("bubble_ready_low", {31'b0, rdy[1][0]}, 0);
    chk("bubble_hold_out", {12'b0, out[1][0]}, 476656);
    step();
    chk("bubble_ready_back", {31'b0, rdy[1][0]}, 1);

    // Random stream with occasional bubbles and weight changes.
    for (int i = 0; i < 30; i++) begin
      rand_inputs();
      in_ready = ($urandom_range(4) != 0);
      step();
    end

    // Mid-operation reset one cycle after a valid capture.
    in_ready = 1'b1;
    rand_inputs();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    in_ready = 1'b0;
    repeat (4) step();
    chk("midrst_out0_node0", {12'b0, out[0][0]}, 0);
    chk("midrst_ready", {31'b0, rdy[2][1]}, 0);

    // Resume after reset.
    in_ready = 1'b1;
    repeat (4) begin
      rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
